pr_freelist_ctrl: RTL and testbench

//  Physical-register free-list controller feeding the rename map table. Each cycle it

---
 rtl/pr_freelist_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pr_freelist_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pr_freelist_ctrl.sv
// Physical-register free-list controller.
// Hands out up to N_WAY free PR tags per cycle, reclaims retiring Told tags, and on
// branch_haz rewinds the allocation pointer to the retired (architectural) point.
// Optional feature: define FL_BYPASS_EN to let starved lanes take this cycle's freed tags.
module pr_freelist_ctrl #(
   parameter int unsigned N_WAY     = 2,
   parameter int unsigned PR_NUM    = 64,
   parameter int unsigned ARCH_REGS = 32,
   parameter int unsigned CDB_BITS  = 6
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_WAY-1:0]          dis_req,
   input  logic                      branch_haz,
   input  logic [N_WAY-1:0]          rt_valid,
   input  logic [N_WAY-1:0]          rt_alloc,
   input  logic [N_WAY*CDB_BITS-1:0] rt_told,
   output logic [N_WAY*CDB_BITS-1:0] pr_freelist,
   output logic                      alloc_stall,
   output logic [CDB_BITS:0]         free_count,
   output logic                      err_overflow
);

   localparam int unsigned DEPTH = PR_NUM - 1;

   typedef enum logic [0:0] {StRun, StRecover} state_t;

   state_t                state;
   logic [CDB_BITS-1:0]   mem [DEPTH];
   logic [CDB_BITS-1:0]   head;
   logic [CDB_BITS-1:0]   tail;
   logic [CDB_BITS-1:0]   arch_head;
   logic [CDB_BITS:0]     count;
   logic                  err;

   logic [CDB_BITS-1:0]   head_nxt;
   logic [CDB_BITS-1:0]   tail_nxt;
   logic [CDB_BITS-1:0]   arch_head_nxt;
   logic [CDB_BITS:0]     count_nxt;
   logic                  err_set;
   logic                  grant_en;
   logic [CDB_BITS-1:0]   freed_tag [N_WAY];
   logic [N_WAY-1:0]      wr_en;
   logic [CDB_BITS-1:0]   wr_idx [N_WAY];
   logic [CDB_BITS-1:0]   wr_tag [N_WAY];
   int unsigned           n_freed;
   int unsigned           n_pop;
   int unsigned           n_byp;
   int unsigned           n_push;
   int unsigned           n_ret;
   int unsigned           space;

   // Pointer increment modulo the storage depth (inc never exceeds N_WAY).
   function automatic logic [CDB_BITS-1:0] wrap_add(input logic [CDB_BITS-1:0] p,
                                                    input int unsigned inc);
      int unsigned s;
      s = 32'(p) + inc;
      if (s >= DEPTH) s = s - DEPTH;
      return CDB_BITS'(s);
   endfunction

   // Occupancy between two pointers; equal pointers read as empty.
   function automatic logic [CDB_BITS:0] ptr_diff(input logic [CDB_BITS-1:0] a,
                                                  input logic [CDB_BITS-1:0] b);
      int unsigned d;
      if (a >= b) d = 32'(a) - 32'(b);
      else        d = 32'(a) + DEPTH - 32'(b);
      return (CDB_BITS+1)'(d);
   endfunction

   assign free_count   = count;
   assign err_overflow = err;

   // Grant selection, push placement and next-pointer computation.
   always_comb begin
      grant_en    = (state == StRun) && !branch_haz;
      pr_freelist = '0;
      alloc_stall = 1'b0;
      err_set     = 1'b0;
      n_freed     = 0;
      n_pop       = 0;
      n_byp       = 0;
      n_push      = 0;
      n_ret       = 0;
      for (int j = 0; j < N_WAY; j++) begin
         freed_tag[j] = '0;
         wr_en[j]     = 1'b0;
         wr_idx[j]    = '0;
         wr_tag[j]    = '0;
      end

      // Compact this cycle's freed tags into retire-lane order.
      for (int l = 0; l < N_WAY; l++) begin
         if (rt_valid[l] && (rt_told[l*CDB_BITS +: CDB_BITS] != '0)) begin
            freed_tag[n_freed] = rt_told[l*CDB_BITS +: CDB_BITS];
            n_freed            = n_freed + 1;
         end
      end

      for (int l = 0; l < N_WAY; l++) begin
         if (dis_req[l]) begin
            if (grant_en && (n_pop < 32'(count))) begin
               pr_freelist[l*CDB_BITS +: CDB_BITS] = mem[wrap_add(head, n_pop)];
               n_pop = n_pop + 1;
            end
`ifdef FL_BYPASS_EN
            else if (grant_en && (n_byp < n_freed)) begin
               pr_freelist[l*CDB_BITS +: CDB_BITS] = freed_tag[n_byp];
               n_byp = n_byp + 1;
            end
`endif
            else begin
               alloc_stall = 1'b1;
            end
         end
      end

      // Bypassed tags are consumed; the rest go to storage while there is room.
      space = DEPTH - (32'(count) - n_pop);
      for (int j = 0; j < N_WAY; j++) begin
         if ((j < n_freed) && (j >= n_byp)) begin
            if (n_push < space) begin
               wr_en[j]  = 1'b1;
               wr_idx[j] = wrap_add(tail, n_push);
               wr_tag[j] = freed_tag[j];
               n_push    = n_push + 1;
            end else begin
               err_set = 1'b1;
            end
         end
      end

      for (int l = 0; l < N_WAY; l++) begin
         if (rt_valid[l] && rt_alloc[l]) n_ret = n_ret + 1;
      end

      arch_head_nxt = wrap_add(arch_head, n_ret);
      tail_nxt      = wrap_add(tail, n_push);
      if (branch_haz) begin
         head_nxt  = arch_head_nxt;
         count_nxt = ptr_diff(tail_nxt, arch_head_nxt);
      end else begin
         head_nxt  = wrap_add(head, n_pop);
         count_nxt = (CDB_BITS+1)'(32'(count) + n_push - n_pop);
      end
   end

   // Recovery FSM, pointers, storage and sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= StRun;
         head      <= '0;
         arch_head <= '0;
         tail      <= CDB_BITS'(DEPTH - ARCH_REGS);
         count     <= (CDB_BITS+1)'(DEPTH - ARCH_REGS);
         err       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= (i < DEPTH - ARCH_REGS) ? CDB_BITS'(ARCH_REGS + 1 + i) : '0;
         end
      end else begin
         unique case (state)
            StRun:     state <= branch_haz ? StRecover : StRun;
            StRecover: state <= branch_haz ? StRecover : StRun;
            default:   state <= StRun;
         endcase
         head      <= head_nxt;
         tail      <= tail_nxt;
         arch_head <= arch_head_nxt;
         count     <= count_nxt;
         if (err_set) err <= 1'b1;
         for (int j = 0; j < N_WAY; j++) begin
            if (wr_en[j]) mem[wr_idx[j]] <= wr_tag[j];
         end
      end
   end

endmodule

// File: tb/tb_pr_freelist_ctrl.sv
// Self-checking bench for pr_freelist_ctrl: directed scenarios, then constrained random
// traffic, checked against a queue model of free tags (fq) and of allocated-but-unretired
// storage entries (sq).
module tb_pr_freelist_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  dis_req;
   logic        branch_haz;
   logic [1:0]  rt_valid;
   logic [1:0]  rt_alloc;
   logic [11:0] rt_told;
   logic [11:0] pr_freelist;
   logic        alloc_stall;
   logic [6:0]  free_count;
   logic        err_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   int fq[$];
   int sq[$];
   bit m_rec;
   bit m_err;

   logic [5:0] obs_pr0, obs_pr1;
   logic       obs_stall;

   pr_freelist_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .dis_req      (dis_req),
      .branch_haz   (branch_haz),
      .rt_valid     (rt_valid),
      .rt_alloc     (rt_alloc),
      .rt_told      (rt_told),
      .pr_freelist  (pr_freelist),
      .alloc_stall  (alloc_stall),
      .free_count   (free_count),
      .err_overflow (err_overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      sq.delete();
      for (int t = 33; t <= 63; t++) fq.push_back(t);
      m_rec = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; dis_req = '0; branch_haz = 1'b0;
      rt_valid = '0; rt_alloc = '0; rt_told = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
      @(negedge clock);
   endtask

   // One cycle: drive, predict and check outputs, clock, advance the model.
   task automatic cyc(input logic [1:0] d, input logic h, input logic [1:0] rv,
                      input logic [1:0] ra, input int t0, input int t1);
      int  fr[$];
      int  tl[2];
      int  et[2];
      int  k, nb, cur, nret;
      logic es;
      bit  allow;
      dis_req = d; branch_haz = h; rt_valid = rv; rt_alloc = ra;
      rt_told = {6'(t1), 6'(t0)};
      tl[0] = t0; tl[1] = t1;
      for (int l = 0; l < 2; l++) if (rv[l] && tl[l] != 0) fr.push_back(tl[l]);
      allow = !m_rec && !h;
      k = 0; nb = 0; es = 1'b0;
      for (int l = 0; l < 2; l++) begin
         et[l] = 0;
         if (d[l]) begin
            if (allow && k < fq.size()) begin
               et[l] = fq[k]; k++;
            end
`ifdef FL_BYPASS_EN
            else if (allow && nb < fr.size()) begin
               et[l] = fr[nb]; nb++;
            end
`endif
            else es = 1'b1;
         end
      end
      #2;
      obs_pr0 = pr_freelist[5:0];
      obs_pr1 = pr_freelist[11:6];
      obs_stall = alloc_stall;
      chk("lane0_tag", 64'(obs_pr0), 64'(et[0]));
      chk("lane1_tag", 64'(obs_pr1), 64'(et[1]));
      chk("alloc_stall", 64'(obs_stall), 64'(es));
      chk("free_count", 64'(free_count), 64'(fq.size()));
      chk("err_overflow", 64'(err_overflow), 64'(m_err));
      @(posedge clock);
      repeat (k) sq.push_back(fq.pop_front());
      cur = fq.size();
      for (int j = nb; j < fr.size(); j++) begin
         if (cur < 63) begin
            fq.push_back(fr[j]); cur++;
         end else m_err = 1'b1;
      end
      nret = int'(rv[0] & ra[0]) + int'(rv[1] & ra[1]);
      repeat (nret) if (sq.size() > 0) void'(sq.pop_front());
      if (h) begin
         fq = {sq, fq};
         sq.delete();
      end
      m_rec = h;
      @(negedge clock);
   endtask

   initial begin
      int guard;
      logic [1:0] d, rv, ra;
      logic h;
      int t0, t1, room, np;

      // Reset state and first allocation.
      do_reset();
      cyc(2'b00, 1'b0, 2'b00, 2'b00, 0, 0);
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("t1_lane0_is_33", 64'(obs_pr0), 64'd33);
      chk("t1_lane1_is_34", 64'(obs_pr1), 64'd34);
      chk("t1_no_stall", 64'(obs_stall), 64'd0);
      #2 chk("t1_count_29", 64'(free_count), 64'd29);

      // Drain to one entry, then a two-lane request gets only lane0.
      guard = 0;
      while (fq.size() > 1 && guard < 40) begin
         cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
         guard++;
      end
      chk("t2_drain_reached_1", 64'(free_count), 64'd1);
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("t2_lane1_zero", 64'(obs_pr1), 64'd0);
      chk("t2_stall", 64'(obs_stall), 64'd1);
      #2 chk("t2_count_0", 64'(free_count), 64'd0);

      // Empty list, tag 5 freed while lane0 requests.
      cyc(2'b01, 1'b0, 2'b01, 2'b00, 5, 0);
      cyc(2'b01, 1'b0, 2'b00, 2'b00, 0, 0);

      // Squash after 4 allocations and 1 retirement.
      do_reset();
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      cyc(2'b00, 1'b0, 2'b01, 2'b01, 0, 0);
      cyc(2'b11, 1'b1, 2'b00, 2'b00, 0, 0);
      chk("t4_haz_lane0_zero", 64'(obs_pr0), 64'd0);
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("t4_recover_stall", 64'(obs_stall), 64'd1);
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("t4_realloc_34", 64'(obs_pr0), 64'd34);
      chk("t4_realloc_35", 64'(obs_pr1), 64'd35);
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);

      // Recovery with two retirements and two frees in the same cycle.
      cyc(2'b00, 1'b1, 2'b11, 2'b11, 9, 7);
      #2 chk("t5_count_30", 64'(free_count), 64'd30);
      cyc(2'b00, 1'b0, 2'b00, 2'b00, 0, 0);
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("t5_first_36", 64'(obs_pr0), 64'd36);

      // Fill to capacity, overflow, sticky flag, reset mid-run.
      do_reset();
      for (int i = 0; i < 16; i++)
         cyc(2'b00, 1'b0, 2'b11, 2'b00, $urandom_range(1, 63), $urandom_range(1, 63));
      chk("t6_full", 64'(free_count), 64'd63);
      cyc(2'b00, 1'b0, 2'b01, 2'b00, 12, 0);
      chk("t6_err_set", 64'(err_overflow), 64'd1);
      cyc(2'b00, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("t6_err_sticky", 64'(err_overflow), 64'd1);
      do_reset();
      cyc(2'b11, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("t6_reinit_33", 64'(obs_pr0), 64'd33);
      chk("t6_reinit_34", 64'(obs_pr1), 64'd34);

      // Random traffic, kept within what legal dispatch/retire can produce.
      for (int i = 0; i < 400; i++) begin
         d  = 2'($urandom);
         h  = ($urandom_range(0, 15) == 0);
         rv = 2'($urandom);
         ra = 2'b00;
         room = sq.size();
         for (int l = 0; l < 2; l++) begin
            if (rv[l] && room > 0 && $urandom_range(0, 1) == 1) begin
               ra[l] = 1'b1;
               room--;
            end
         end
         t0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
         t1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
         np = int'(rv[0] && t0 != 0) + int'(rv[1] && t1 != 0);
         if (fq.size() + sq.size() + np > 62) begin
            t0 = 0;
            t1 = 0;
         end
         cyc(d, h, rv, ra, t0, t1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
